// File: rtl/codec_sched_pkg.sv
// Shared definitions for the frame-buffer codec scheduler.
// FSM state encoding, active_op codes and the default watchdog limit.
package codec_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMP_REQ = 3'd1,
        S_CMP_RUN = 3'd2,
        S_DEC_REQ = 3'd3,
        S_DEC_RUN = 3'd4
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    localparam logic [19:0] TIMEOUT_DEF = 20'd1000000;

endpackage

// File: rtl/codec_scheduler_if.sv
// Request/finish/status bundle between timing logic, scheduler and codec control.
// master = surrounding logic, slave = the scheduler.
interface codec_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             frame_wr_req;
    logic             display_rd_req;
    logic             compress_request;
    logic             compress_finish;
    logic             decompress_request;
    logic             decompress_finish;
    logic             frame_valid;
    logic             busy;
    logic [1:0]       active_op;
    logic             timeout_err;
    logic             err_clr;
    logic [CNT_W-1:0] overrun_cnt;

    modport master (
        output enable, frame_wr_req, display_rd_req,
        output compress_finish, decompress_finish, err_clr,
        input  compress_request, decompress_request,
        input  frame_valid, busy, active_op,
        input  timeout_err, overrun_cnt
    );

    modport slave (
        input  enable, frame_wr_req, display_rd_req,
        input  compress_finish, decompress_finish, err_clr,
        output compress_request, decompress_request,
        output frame_valid, busy, active_op,
        output timeout_err, overrun_cnt
    );
endinterface

// File: rtl/codec_scheduler_watchdog.sv
// Per-operation watchdog: cleared while a request is issued, counts RUN cycles.
// expired flags the last permitted RUN cycle.
module op_watchdog
    import codec_sched_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_CYCLES - 1'b1;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/codec_scheduler.sv
// Arbitrates the shared compress/decompress engine between capture and display.
// Decompress has priority unless it also took the previous grant.
module codec_scheduler
    import codec_sched_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int                   CNT_W          = 8
) (
    input logic              clock,
    input logic              reset_n,
    codec_scheduler_if.slave bus
);
    state_t           state_q, state_d;
    logic             cmp_pend_q, cmp_pend_d;
    logic             dec_pend_q, dec_pend_d;
    logic             last_dec_q, last_dec_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;
    logic             creq_q, creq_d;
    logic             dreq_q, dreq_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;

    logic             grant_cmp, grant_dec, tmo;
    logic             cmp_elig, dec_elig;
    logic [1:0]       ovr_inc;
    logic [CNT_W:0]   ovr_sum;
    logic             wd_clr, wd_run, wd_exp;

    assign wd_clr = (state_q == S_CMP_REQ) || (state_q == S_DEC_REQ);
    assign wd_run = (state_q == S_CMP_RUN) || (state_q == S_DEC_RUN);

    op_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (wd_clr),
        .run     (wd_run),
        .expired (wd_exp)
    );

    always_comb begin
        state_d    = state_q;
        fv_d       = fv_q;
        last_dec_d = last_dec_q;
        grant_cmp  = 1'b0;
        grant_dec  = 1'b0;
        tmo        = 1'b0;
        cmp_elig   = cmp_pend_q;
        dec_elig   = dec_pend_q & fv_q;

        case (state_q)
            S_IDLE: begin
                if (bus.enable && dec_elig && !(cmp_elig && last_dec_q)) begin
                    state_d   = S_DEC_REQ;
                    grant_dec = 1'b1;
                end else if (bus.enable && cmp_elig) begin
                    state_d   = S_CMP_REQ;
                    grant_cmp = 1'b1;
                end
            end
            S_CMP_REQ: state_d = S_CMP_RUN;
            S_DEC_REQ: state_d = S_DEC_RUN;
            S_CMP_RUN: begin
                if (bus.compress_finish) begin
                    state_d    = S_IDLE;
                    fv_d       = 1'b1;
                    last_dec_d = 1'b0;
                end else if (wd_exp) begin
                    // aborted compress leaves a partial frame behind
                    state_d = S_IDLE;
                    fv_d    = 1'b0;
                    tmo     = 1'b1;
                end
            end
            S_DEC_RUN: begin
                if (bus.decompress_finish) begin
                    state_d    = S_IDLE;
                    last_dec_d = 1'b1;
                end else if (wd_exp) begin
                    state_d = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmp_pend_d = (cmp_pend_q & ~grant_cmp) | bus.frame_wr_req;
        dec_pend_d = (dec_pend_q & ~grant_dec) | bus.display_rd_req;

        ovr_inc = {1'b0, bus.frame_wr_req & cmp_pend_q}
                + {1'b0, bus.display_rd_req & dec_pend_q};
        ovr_sum = {1'b0, ovr_q} + (CNT_W + 1)'(ovr_inc);
        ovr_d   = ovr_sum[CNT_W] ? '1 : ovr_sum[CNT_W-1:0];

        err_d = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
            ovr_d = '0;
        end
        if (tmo) begin
            err_d = 1'b1;
        end

        creq_d = (state_d == S_CMP_REQ);
        dreq_d = (state_d == S_DEC_REQ);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cmp_pend_q <= 1'b0;
            dec_pend_q <= 1'b0;
            last_dec_q <= 1'b0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            creq_q     <= 1'b0;
            dreq_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmp_pend_q <= cmp_pend_d;
            dec_pend_q <= dec_pend_d;
            last_dec_q <= last_dec_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            creq_q     <= creq_d;
            dreq_q     <= dreq_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        case (state_q)
            S_CMP_REQ, S_CMP_RUN: bus.active_op = OP_CMP;
            S_DEC_REQ, S_DEC_RUN: bus.active_op = OP_DEC;
            default:              bus.active_op = OP_NONE;
        endcase
    end

    assign bus.busy               = (state_q != S_IDLE);
    assign bus.compress_request   = creq_q;
    assign bus.decompress_request = dreq_q;
    assign bus.frame_valid        = fv_q;
    assign bus.timeout_err        = err_q;
    assign bus.overrun_cnt        = ovr_q;

endmodule

// File: tb/tb_codec_scheduler.sv
// Bench for codec_scheduler: directed scenarios plus random traffic
// checked every cycle against an operation-level model.
module tb_codec_scheduler;
    localparam int TO   = 16;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    codec_scheduler_if #(.CNT_W(CW)) ifc ();

    codec_scheduler #(
        .TIMEOUT_W      (20),
        .TIMEOUT_CYCLES (20'd16),
        .CNT_W          (CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clock = ~clock;

    int vec = 0;
    int mis = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Operation-level model: which op owns the engine, whether its request
    // pulse is showing, and how many RUN cycles it has used.
    bit m_cp, m_dp, m_fv, m_err, m_last_dec, m_issue;
    int m_op, m_elapsed, m_ovc;

    task automatic model_step();
        bit wr = ifc.frame_wr_req;
        bit rd = ifc.display_rd_req;
        bit cf = ifc.compress_finish;
        bit df = ifc.decompress_finish;
        bit ec = ifc.err_clr;
        bit en = ifc.enable;
        bit gc = 0;
        bit gd = 0;
        int ov;
        ov = int'(wr && m_cp) + int'(rd && m_dp);
        if (ec) begin
            m_err = 0;
            m_ovc = 0;
        end else begin
            m_ovc = (m_ovc + ov > CMAX) ? CMAX : m_ovc + ov;
        end
        if (m_op == 0) begin
            if (en && m_dp && m_fv && !(m_cp && m_last_dec)) gd = 1;
            else if (en && m_cp) gc = 1;
        end else if (m_issue) begin
            m_issue   = 0;
            m_elapsed = 0;
        end else if ((m_op == 1 && cf) || (m_op == 2 && df)) begin
            if (m_op == 1) begin
                m_fv       = 1;
                m_last_dec = 0;
            end else begin
                m_last_dec = 1;
            end
            m_op = 0;
        end else if (m_elapsed == TO - 1) begin
            m_err = 1;
            if (m_op == 1) m_fv = 0;
            m_op = 0;
        end else begin
            m_elapsed++;
        end
        m_cp = (m_cp && !gc) || wr;
        m_dp = (m_dp && !gd) || rd;
        if (gc) begin m_op = 1; m_issue = 1; end
        if (gd) begin m_op = 2; m_issue = 1; end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cp = 0; m_dp = 0; m_fv = 0; m_err = 0;
            m_last_dec = 0; m_issue = 0;
            m_op = 0; m_elapsed = 0; m_ovc = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("compress_request", ifc.compress_request,
                32'(m_op == 1 && m_issue));
            chk("decompress_request", ifc.decompress_request,
                32'(m_op == 2 && m_issue));
            chk("busy", ifc.busy, 32'(m_op != 0));
            chk("active_op", ifc.active_op, m_op);
            chk("frame_valid", ifc.frame_valid, 32'(m_fv));
            chk("timeout_err", ifc.timeout_err, 32'(m_err));
            chk("overrun_cnt", ifc.overrun_cnt, m_ovc);
        end
    end

    int gq[$];
    bit mon_on = 0;
    always @(negedge clock) begin
        if (mon_on && reset_n) begin
            if (ifc.compress_request)   gq.push_back(1);
            if (ifc.decompress_request) gq.push_back(2);
        end
    end

    task automatic drive(input bit wr = 0, input bit rd = 0,
                         input bit cf = 0, input bit df = 0,
                         input bit ec = 0);
        ifc.frame_wr_req      = wr;
        ifc.display_rd_req    = rd;
        ifc.compress_finish   = cf;
        ifc.decompress_finish = df;
        ifc.err_clr           = ec;
        @(negedge clock);
        ifc.frame_wr_req      = 0;
        ifc.display_rd_req    = 0;
        ifc.compress_finish   = 0;
        ifc.decompress_finish = 0;
        ifc.err_clr           = 0;
    endtask

    task automatic apply_reset();
        reset_n = 0;
        drive();
        drive();
        reset_n = 1;
    endtask

    task automatic serve();
        bit got = 0;
        int k;
        for (int i = 0; i < 40; i++) begin
            drive();
            if (ifc.compress_request || ifc.decompress_request) begin
                got = 1;
                break;
            end
        end
        chk("serve_grant", 32'(got), 1);
        if (got) begin
            k = int'(ifc.active_op);
            drive();
            drive();
            if (k == 1) drive(.cf(1));
            else drive(.df(1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int ndec;
        int exp_order[6];
        ifc.enable = 1;
        ifc.frame_wr_req = 0;
        ifc.display_rd_req = 0;
        ifc.compress_finish = 0;
        ifc.decompress_finish = 0;
        ifc.err_clr = 0;
        @(negedge clock);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_fv", ifc.frame_valid, 0);
        apply_reset();
        chk("rst_active", ifc.active_op, 0);
        chk("rst_ovr", ifc.overrun_cnt, 0);

        // request at cycle 5, pulse at cycle 7, finish 10 cycles later
        repeat (4) drive();
        drive(.wr(1));
        chk("t1_no_pulse_yet", ifc.compress_request, 0);
        drive();
        chk("t1_cmp_pulse", ifc.compress_request, 1);
        chk("t1_active", ifc.active_op, 1);
        drive();
        chk("t1_pulse_gone", ifc.compress_request, 0);
        chk("t1_active_run", ifc.active_op, 1);
        repeat (7) drive();
        drive(.cf(1));
        chk("t1_fv", ifc.frame_valid, 1);
        chk("t1_idle", ifc.active_op, 0);

        // display request waits for a valid frame
        apply_reset();
        drive(.rd(1));
        drive();
        drive();
        chk("t2_dec_waits", ifc.busy, 0);
        drive(.wr(1));
        drive();
        chk("t2_cmp_first", ifc.compress_request, 1);
        drive();
        drive(.cf(1));
        chk("t2_no_dec_yet", ifc.decompress_request, 0);
        drive();
        chk("t2_dec_pulse", ifc.decompress_request, 1);
        chk("t2_ovr", ifc.overrun_cnt, 0);
        drive();
        drive(.df(1));

        // make the previous grant a compress, then tie three times
        drive(.wr(1));
        drive();
        drive();
        drive(.cf(1));
        gq.delete();
        mon_on = 1;
        repeat (3) begin
            drive(.wr(1), .rd(1));
            serve();
            serve();
        end
        mon_on = 0;
        exp_order = '{2, 1, 2, 1, 2, 1};
        chk("t3_grants", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            chk("t3_order", gq[i], exp_order[i]);

        // compress never finishes: 1 REQ + 16 RUN cycles then abort
        chk("t4_fv_before", ifc.frame_valid, 1);
        drive(.wr(1));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive();
            if (ifc.active_op == 2'b01) n++;
            else break;
        end
        chk("t4_op_cycles", n, 17);
        chk("t4_err", ifc.timeout_err, 1);
        chk("t4_fv_cleared", ifc.frame_valid, 0);
        drive(.ec(1));
        chk("t4_err_clr", ifc.timeout_err, 0);

        // overruns during a compress, one decompress follows
        gq.delete();
        mon_on = 1;
        drive(.wr(1));
        drive();
        drive(.rd(1));
        drive(.rd(1));
        drive();
        drive(.rd(1));
        drive(.cf(1));
        chk("t5_ovr", ifc.overrun_cnt, 2);
        serve();
        repeat (4) drive();
        mon_on = 0;
        ndec = 0;
        foreach (gq[i]) if (gq[i] == 2) ndec++;
        chk("t5_one_dec", ndec, 1);
        drive(.ec(1));
        chk("t5_ovr_clr", ifc.overrun_cnt, 0);
        ifc.enable = 0;
        repeat (6) drive(.wr(1));
        chk("t5_ovr_sat", ifc.overrun_cnt, 3);
        chk("t5_no_grant", ifc.busy, 0);
        ifc.enable = 1;
        drive();
        chk("t5_grant_on_en", ifc.compress_request, 1);
        drive();
        drive(.cf(1));

        // async reset in the middle of a decompress
        drive(.rd(1));
        drive();
        drive();
        chk("t6_dec_run", ifc.active_op, 2);
        #2 reset_n = 0;
        #1;
        chk("t6_busy0", ifc.busy, 0);
        chk("t6_op0", ifc.active_op, 0);
        chk("t6_fv0", ifc.frame_valid, 0);
        chk("t6_dreq0", ifc.decompress_request, 0);
        @(negedge clock);
        reset_n = 1;
        drive(.df(1));
        chk("t6_finish_ignored", ifc.busy, 0);
        chk("t6_fv_still0", ifc.frame_valid, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ifc.enable = ($urandom_range(0, 9) != 0);
            drive(.wr($urandom_range(0, 7) == 0),
                  .rd($urandom_range(0, 7) == 0),
                  .cf($urandom_range(0, 4) == 0),
                  .df($urandom_range(0, 4) == 0),
                  .ec($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/codec_scheduler.md
Name: codec_scheduler

Overview:
- Shares the single frame-buffer compress/decompress engine between the capture side (new frame to compress) and the display side (frame to decompress for refresh).
- Latches requests, arbitrates with decompress priority plus anti-starvation, and issues one-cycle request pulses to the codec control block.
- Tracks completion, maintains a frame-valid flag, and guards each operation with a watchdog.
- Sits between the capture/display timing logic and the codec control block.

Parameters:
- TIMEOUT_W, 20, width of the watchdog counter.
- TIMEOUT_CYCLES, 20'd1000000, cycles in a RUN state before abort; must be >= 2.
- CNT_W, 8, width of the saturating overrun counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset
- enable  in  1  level; 0 = no new grants, current op runs to completion
- frame_wr_req  in  1  pulse: captured frame ready to compress
- display_rd_req  in  1  pulse: display needs a decompressed frame
- compress_request  out  1  one-cycle pulse to codec control
- compress_finish  in  1  pulse from engine: compression done
- decompress_request  out  1  one-cycle pulse to codec control
- decompress_finish  in  1  pulse from engine: decompression done
- frame_valid  out  1  buffer holds a complete compressed frame
- busy  out  1  state != IDLE
- active_op  out  2  00 none, 01 compress, 10 decompress
- timeout_err  out  1  sticky watchdog abort flag
- err_clr  in  1  pulse: clears timeout_err and overrun_cnt
- overrun_cnt  out  CNT_W  saturating count of requests arriving while the same kind is already pending

Behaviour:
- Reset: the clock is the single clock; reset_n is asynchronous, active-low. All outputs, both pending flags, last_dec, the watchdog and the state register reset to 0 / IDLE.
- Pending flags cmp_pend and dec_pend:
  - Each is set on its request pulse and cleared on the cycle its grant enters X_REQ.
  - A request arriving in the grant cycle leaves the flag set.
  - A request arriving while the flag is already set increments overrun_cnt, saturating at all-ones. Two simultaneous overruns add 2, also saturating.
- Eligibility: cmp_elig = cmp_pend. dec_elig = dec_pend & frame_valid. A display request with no valid frame waits.
- FSM states: IDLE, CMP_REQ, CMP_RUN, DEC_REQ, DEC_RUN.
  - IDLE -> DEC_REQ when enable & dec_elig & !(cmp_elig & last_dec).
  - IDLE -> CMP_REQ when enable & cmp_elig otherwise.
  - Tie rule: decompress wins unless the previous grant was also a decompress.
  - CMP_REQ -> CMP_RUN and DEC_REQ -> DEC_RUN unconditionally after 1 cycle.
  - compress_request / decompress_request are registered and high exactly during X_REQ.
  - CMP_RUN -> IDLE on compress_finish; set frame_valid, last_dec<=0.
  - DEC_RUN -> IDLE on decompress_finish; last_dec<=1.
  - Finish pulses in any other state, or of the wrong kind, are ignored.
- Latency: request sampled at edge k -> pending at k; if IDLE and enabled, X_REQ from edge k+1, so the pulse is visible 1 cycle after pending. A finish at edge m -> IDLE at m; the next grant X_REQ is at m+1 at the earliest.
- Watchdog:
  - Clears on entry to X_RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a finish: go to IDLE, set timeout_err. If the aborted op is a compress, also clear frame_valid (partial frame).
  - A finish in the same cycle as expiry counts as a finish, with no error.
  - err_clr in the same cycle as a new timeout: the error remains set.
- compress start while frame_valid=1: frame_valid stays 1 until the abort case; the buffer is overwritten in place.
- enable deasserted mid-op: the op completes normally and pending flags are retained.
- active_op and busy are decoded from the registered state.
- Counter widths are fixed; no arithmetic wraps.

Decomposition:
- Package codec_sched_pkg holds:
  - state encoding localparams (S_IDLE..S_DEC_RUN, 3-bit);
  - active_op codes OP_NONE/OP_CMP/OP_DEC;
  - default TIMEOUT_CYCLES.
- One sub-module, op_watchdog (inputs clr, run; output expired; parameterised TIMEOUT_W/TIMEOUT_CYCLES). Everything else stays in the top module.

Test Plan:
- Reset, then frame_wr_req at cycle 5, compress_finish 10 cycles after compress_request -> compress_request high exactly cycle 7, frame_valid=1 after the finish edge, active_op 01 during the op.
- display_rd_req with frame_valid=0, then frame_wr_req -> compress runs first; decompress_request pulses 2 cycles after compress_finish; overrun_cnt=0.
- frame_valid=1, frame_wr_req and display_rd_req in the same cycle, repeated 3 times with finishes -> grant order DEC, CMP, DEC, CMP (alternation; no starvation).
- TIMEOUT_CYCLES=16, compress with no finish -> IDLE after 16 RUN cycles, timeout_err=1, frame_valid=0; err_clr -> timeout_err=0.
- Three display_rd_req during a long compress -> overrun_cnt=2, a single decompress granted; with CNT_W=2 and 5 overruns -> saturates at 3.
- reset_n asserted mid DEC_RUN -> all outputs 0 immediately; a decompress_finish after release is ignored; enable=0 with pending cmp -> no compress_request until enable=1.
